alu_rr_sched: RTL
=================

Name: alu_rr_sched

Overview:
- Two-requester round-robin scheduler that shares one alu instance (ops ADD..DIV, simple/complex mode, four 16-bit operands, two 32-bit results).
- Accepts one command at a time over valid/ready, drives registered operands to the ALU, and waits ALU_LAT cycles.
- Captures out1/out2 and returns them to the issuing requester over valid/ready.
- Sits between the two command sources and the alu in the compute top level.

Parameters:
- ALU_LAT, 1, cycles between operand register update and result capture (≥1; covers a combinational or pipelined alu).
- DW, 16, operand width; result width is 2*DW.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_req0_valid / i_req1_valid  in  1  command valid, per requester.
- o_req0_ready / o_req1_ready  out  1  command accepted this cycle.
- i_req0_mode / i_req1_mode  in  1  0 simple, 1 complex.
- i_req0_op / i_req1_op  in  4  opcode.
- i_req0_data / i_req1_data  in  4*DW  {A,B,C,D}, A in MSBs.
- o_rsp0_valid / o_rsp1_valid  out  1  result valid for requester 0/1.
- i_rsp0_ready / i_rsp1_ready  in  1  requester takes result.
- o_rsp_data  out  4*DW  {out1,out2}, shared by both requesters.
- o_rsp_err  out  1  illegal command flag (see Optional Feature).
- o_alu_mode  out  1  to alu i_mode.
- o_alu_op  out  4  to alu i_op.
- o_alu_a, o_alu_b, o_alu_c, o_alu_d  out  DW  to alu i_A..i_D.
- i_alu_out1, i_alu_out2  in  2*DW  from alu.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE, last_grant=1 so requester 0 wins first.
  - All o_* = 0, including ALU operands and op.
  - Counter = 0.
- FSM IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - grant = requester 0 if only 0 valid; 1 if only 1 valid; if both valid, the one != last_grant.
  - o_reqN_ready = (state==IDLE) && grant==N. It is combinational from valid and state, and never high for both requesters.
  - Handshake at edge E0 (valid&&ready):
    - register mode/op/A..D onto o_alu_*;
    - latch owner=grant and last_grant=grant;
    - counter=ALU_LAT-1; go EXEC.
- EXEC:
  - o_alu_* held stable; no ready asserted.
  - counter decrements each cycle; at counter==0, capture {i_alu_out1,i_alu_out2} into o_rsp_data and go RESP.
  - Result is valid at edge E0+ALU_LAT.
- RESP:
  - o_rsp<owner>_valid=1; the other rsp_valid stays 0.
  - o_rsp_data is stable until handshake.
  - On i_rsp<owner>_ready go IDLE, drop valid, keep o_rsp_data and o_alu_* unchanged.
  - The non-owner's i_rspN_ready is ignored.
- Throughput: max one command per ALU_LAT+2 cycles (IDLE handshake cycle, ALU_LAT EXEC cycles, ≥1 RESP cycle).
- Fairness: with both valid continuously, grants strictly alternate 0,1,0,1.
- A requester dropping valid before handshake is legal; nothing is latched.
- No command is accepted while EXEC/RESP; a held valid waits.
- Reset mid-EXEC/RESP: in-flight command is dropped, no response is issued, and state returns to reset values immediately.
- Result width: out1/out2 passed verbatim (2*DW bits); no truncation or sign handling in the scheduler.

Optional Feature:
- Macro ALU_RR_SCHED_ILLEGAL_CHK_EN.
- Defined:
  - In IDLE, an accepted command with op>8, or mode=1 with op in 2..6 (shifts/rotates have no complex form), is not issued to the ALU.
  - o_alu_* keep their previous values; FSM goes straight to RESP next cycle.
  - o_rsp_data=0 and o_rsp_err=1, cleared on the response handshake.
- Undefined: all commands are issued unchanged and o_rsp_err is tied 0.

Decomposition:
- Package alu_pkg:
  - opcode localparams ADD=0, SUB=1, SLL=2, SRL=3, SRA=4, SCL=5, SCR=6, MUL=7, DIV=8;
  - MODE_SIMPLE=0, MODE_COMPLEX=1;
  - state encoding IDLE/EXEC/RESP.
- Sub-module rr_arb2: a 2-way round-robin grant from two valids plus last_grant, purely combinational.
- The alu is not instantiated inside; the top level wires o_alu_* to it.

Test Plan:
- Req0 mode0 ADD {10,5,100,75}, rsp0_ready=1, ALU_LAT=1 -> o_rsp0_valid one cycle after accept, o_rsp_data={15,175}.
- After reset, both valid same cycle: req0 mode1 MUL {2,3,3,1}, req1 mode0 SUB {10,5,100,75} -> req0 served first with {3,11}, then req1 with {5,25}; never both ready.
- Both held valid for 6 commands -> grant order 0,1,0,1,0,1.
- i_rsp1_ready low 5 cycles in RESP (DIV {50,10,1000,20}) -> o_rsp_data={5,50} stable, both req_ready stay 0, return to IDLE the cycle after ready.
- i_rst pulsed mid-EXEC with ALU_LAT=3 -> all outputs 0 immediately, no rsp_valid, next command is granted to requester 0.
- With ALU_RR_SCHED_ILLEGAL_CHK_EN: mode1 op=SLL or op=4'd9 -> no change on o_alu_*, o_rsp_err=1, data 0. Without the macro: o_rsp_err=0 and the op reaches o_alu_op.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcodes, operating modes and scheduler state encoding
package alu_pkg;

    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] SLL = 4'd2;
    localparam logic [3:0] SRL = 4'd3;
    localparam logic [3:0] SRA = 4'd4;
    localparam logic [3:0] SCL = 4'd5;
    localparam logic [3:0] SCR = 4'd6;
    localparam logic [3:0] MUL = 4'd7;
    localparam logic [3:0] DIV = 4'd8;

    localparam logic MODE_SIMPLE  = 1'b0;
    localparam logic MODE_COMPLEX = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    // Opcodes past DIV do not exist; shifts and rotates have no complex form
    function automatic logic is_illegal_cmd(input logic mode, input logic [3:0] op);
        return (op > DIV) || ((mode == MODE_COMPLEX) && (op >= SLL) && (op <= SCR));
    endfunction

endpackage

// File: rtl/alu_rr_sched_rr_arb2.sv
// rtl/alu_rr_sched_rr_arb2.sv - two-way round-robin grant, purely combinational
module rr_arb2 (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last_grant,
    output logic o_grant_valid,
    output logic o_grant
);

    // Lone requester wins; on contention the requester not served last wins
    always_comb begin
        o_grant_valid = i_valid0 | i_valid1;
        o_grant       = 1'b0;
        if (i_valid0 && i_valid1) begin
            o_grant = ~i_last_grant;
        end else if (i_valid1) begin
            o_grant = 1'b1;
        end
    end

endmodule

// File: rtl/alu_rr_sched.sv
// rtl/alu_rr_sched.sv - round-robin front end sharing one ALU between two requesters (option: ALU_RR_SCHED_ILLEGAL_CHK_EN)
module alu_rr_sched
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int DW      = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req0_valid,
    input  logic          i_req1_valid,
    output logic          o_req0_ready,
    output logic          o_req1_ready,
    input  logic          i_req0_mode,
    input  logic          i_req1_mode,
    input  logic [3:0]    i_req0_op,
    input  logic [3:0]    i_req1_op,
    input  logic [4*DW-1:0] i_req0_data,
    input  logic [4*DW-1:0] i_req1_data,
    output logic          o_rsp0_valid,
    output logic          o_rsp1_valid,
    input  logic          i_rsp0_ready,
    input  logic          i_rsp1_ready,
    output logic [4*DW-1:0] o_rsp_data,
    output logic          o_rsp_err,
    output logic          o_alu_mode,
    output logic [3:0]    o_alu_op,
    output logic [DW-1:0] o_alu_a,
    output logic [DW-1:0] o_alu_b,
    output logic [DW-1:0] o_alu_c,
    output logic [DW-1:0] o_alu_d,
    input  logic [2*DW-1:0] i_alu_out1,
    input  logic [2*DW-1:0] i_alu_out2
);

    localparam int            CW       = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT - 1);

    sched_state_t    r_state;
    sched_state_t    w_state_nxt;
    logic            r_last_grant;
    logic            r_owner;
    logic [CW-1:0]   r_cnt;
    logic            r_alu_mode;
    logic [3:0]      r_alu_op;
    logic [DW-1:0]   r_alu_a;
    logic [DW-1:0]   r_alu_b;
    logic [DW-1:0]   r_alu_c;
    logic [DW-1:0]   r_alu_d;
    logic [4*DW-1:0] r_rsp_data;
    logic            r_rsp_err;

    logic            w_grant_valid;
    logic            w_grant;
    logic            w_accept;
    logic            w_exec_done;
    logic            w_rsp_hs;
    logic            w_illegal;
    logic            w_sel_mode;
    logic [3:0]      w_sel_op;
    logic [4*DW-1:0] w_sel_data;

    rr_arb2 u_arb (
        .i_valid0      (i_req0_valid),
        .i_valid1      (i_req1_valid),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant       (w_grant)
    );

    // Ready is masked during reset so every output reads zero while i_rst is high
    assign w_accept     = (r_state == IDLE) && w_grant_valid && !i_rst;
    assign o_req0_ready = w_accept && !w_grant;
    assign o_req1_ready = w_accept && w_grant;

    assign w_sel_mode = w_grant ? i_req1_mode : i_req0_mode;
    assign w_sel_op   = w_grant ? i_req1_op   : i_req0_op;
    assign w_sel_data = w_grant ? i_req1_data : i_req0_data;

`ifdef ALU_RR_SCHED_ILLEGAL_CHK_EN
    assign w_illegal = is_illegal_cmd(w_sel_mode, w_sel_op);
`else
    assign w_illegal = 1'b0;
`endif

    assign w_exec_done = (r_state == EXEC) && (r_cnt == '0);
    assign w_rsp_hs    = (r_state == RESP) && (r_owner ? i_rsp1_ready : i_rsp0_ready);

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: illegal commands skip EXEC and answer directly
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_state_nxt = w_illegal ? RESP : EXEC;
            EXEC:    if (w_exec_done) w_state_nxt = RESP;
            RESP:    if (w_rsp_hs)    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping and ALU latency counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_cnt        <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
            r_owner      <= w_grant;
            r_cnt        <= CNT_INIT;
        end else if ((r_state == EXEC) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // ALU operand registers, held from accept until the next legal accept
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_alu_mode <= 1'b0;
            r_alu_op   <= 4'd0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_c    <= '0;
            r_alu_d    <= '0;
        end else if (w_accept && !w_illegal) begin
            r_alu_mode <= w_sel_mode;
            r_alu_op   <= w_sel_op;
            r_alu_a    <= w_sel_data[4*DW-1:3*DW];
            r_alu_b    <= w_sel_data[3*DW-1:2*DW];
            r_alu_c    <= w_sel_data[2*DW-1:DW];
            r_alu_d    <= w_sel_data[DW-1:0];
        end
    end

    // Response data and error flag; data survives the handshake untouched
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else if (w_accept && w_illegal) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
        end else if (w_exec_done) begin
            r_rsp_data <= {i_alu_out1, i_alu_out2};
        end else if (w_rsp_hs) begin
            r_rsp_err  <= 1'b0;
        end
    end

    assign o_rsp0_valid = (r_state == RESP) && !r_owner;
    assign o_rsp1_valid = (r_state == RESP) && r_owner;
    assign o_rsp_data   = r_rsp_data;
    assign o_rsp_err    = r_rsp_err;
    assign o_alu_mode   = r_alu_mode;
    assign o_alu_op     = r_alu_op;
    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_c      = r_alu_c;
    assign o_alu_d      = r_alu_d;

endmodule
